// File: rtl/bound_flasher_pkg.sv
// Shared types and fixed bounds for the 16-lamp bound flasher.
// State encoding here is also what the optional debug port exposes.
package bound_flasher_pkg;

   localparam int         N_LED_DEF = 16;
   localparam int         CW        = 5;

   localparam logic [4:0] C_FULL  = 5'd16;
   localparam logic [4:0] C_MID   = 5'd5;
   localparam logic [4:0] C_HIGH  = 5'd11;
   localparam logic [4:0] C_LOW   = 5'd6;
   localparam logic [4:0] C_ZERO  = 5'd0;

   localparam logic [4:0] KICK_LO = 5'd6;
   localparam logic [4:0] KICK_HI = 5'd11;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      UP15 = 3'd1,
      KB0  = 3'd2,
      DN5  = 3'd3,
      UP10 = 3'd4,
      DN0  = 3'd5,
      UP5  = 3'd6,
      DNE  = 3'd7
   } bf_state_e;

   function automatic logic is_kick(logic [4:0] c);
      return (c == KICK_LO) || (c == KICK_HI);
   endfunction

endpackage

// File: rtl/bound_flasher_core_therm_dec.sv
// Lit-lamp count to thermometer code: lamp i is on when count > i.
// Counts above N_LED saturate to all lamps lit.
module bf_therm_dec
   import bound_flasher_pkg::*;
#(
   parameter int N_LED = N_LED_DEF
) (
   input  logic [CW-1:0]    cnt_i,
   output logic [N_LED-1:0] led_o
);

   always_comb begin
      led_o = '0;
      for (int i = 0; i < N_LED; i++) begin
         led_o[i] = (cnt_i > CW'(i));
      end
   end

endmodule

// File: rtl/bound_flasher_core.sv
// Bound flasher: thermometer bar grows/shrinks 16,5,11,0,6,0 with kickbacks.
// Define BOUND_FLASHER_STATE_OUT_EN to expose the FSM state on state_o.
module bound_flasher_core
   import bound_flasher_pkg::*;
#(
   parameter int N_LED = N_LED_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flick,
   output logic [N_LED-1:0] LED
`ifdef BOUND_FLASHER_STATE_OUT_EN
   ,
   output logic [2:0]       state_o
`endif
);

   bf_state_e        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N_LED-1:0] led_q, led_d;

   // Every turning point shows its bound for one cycle, then steps the other way.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = C_ZERO;
            if (flick) begin
               cnt_d   = 5'd1;
               state_d = UP15;
            end
         end
         UP15: begin
            if (flick && is_kick(cnt_q)) begin
               cnt_d   = cnt_q - 5'd1;
               state_d = KB0;
            end else if (cnt_q == C_FULL) begin
               cnt_d   = cnt_q - 5'd1;
               state_d = DN5;
            end else begin
               cnt_d   = cnt_q + 5'd1;
            end
         end
         KB0: begin
            if (cnt_q == C_ZERO) begin
               cnt_d   = 5'd1;
               state_d = UP15;
            end else begin
               cnt_d   = cnt_q - 5'd1;
            end
         end
         DN5: begin
            if (cnt_q == C_MID) begin
               cnt_d   = cnt_q + 5'd1;
               state_d = UP10;
            end else begin
               cnt_d   = cnt_q - 5'd1;
            end
         end
         UP10: begin
            if (cnt_q == C_HIGH) begin
               cnt_d   = cnt_q - 5'd1;
               state_d = flick ? DN5 : DN0;
            end else begin
               cnt_d   = cnt_q + 5'd1;
            end
         end
         DN0: begin
            if (cnt_q == C_ZERO) begin
               cnt_d   = 5'd1;
               state_d = UP5;
            end else begin
               cnt_d   = cnt_q - 5'd1;
            end
         end
         UP5: begin
            if (cnt_q == C_LOW) begin
               cnt_d   = cnt_q - 5'd1;
               state_d = DNE;
            end else begin
               cnt_d   = cnt_q + 5'd1;
            end
         end
         DNE: begin
            if (cnt_q == C_ZERO) begin
               state_d = IDLE;
            end else begin
               cnt_d   = cnt_q - 5'd1;
            end
         end
         default: begin
            cnt_d   = C_ZERO;
            state_d = IDLE;
         end
      endcase
   end

   bf_therm_dec #(
      .N_LED (N_LED)
   ) u_dec (
      .cnt_i (cnt_d),
      .led_o (led_d)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= C_ZERO;
         led_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         led_q   <= led_d;
      end
   end

   assign LED = led_q;

`ifdef BOUND_FLASHER_STATE_OUT_EN
   assign state_o = state_q;
`endif

endmodule

// File: tb/tb_bound_flasher_core.sv
// Directed bench for bound_flasher_core with an expected-LED scoreboard queue.
// Expected values are pushed as ramps and popped one per clock.
module tb_bound_flasher_core;
   import bound_flasher_pkg::*;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        flick = 1'b0;
   logic [15:0] LED;
`ifdef BOUND_FLASHER_STATE_OUT_EN
   logic [2:0]  state_o;
`endif

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   bound_flasher_core dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flick (flick),
      .LED   (LED)
`ifdef BOUND_FLASHER_STATE_OUT_EN
      ,
      .state_o (state_o)
`endif
   );

   function automatic logic [15:0] therm(int c);
      logic [16:0] v;
      v = (17'd1 << c) - 17'd1;
      return v[15:0];
   endfunction

   task automatic push_ramp(int a, int b);
      int s;
      s = (b >= a) ? 1 : -1;
      for (int c = a; c != b + s; c += s) exp_q.push_back(therm(c));
   endtask

   task automatic push_n(int c, int n);
      for (int i = 0; i < n; i++) exp_q.push_back(therm(c));
   endtask

   task automatic drain(string tag);
      logic [15:0] e;
      while (exp_q.size() > 0) begin
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_chk++;
         assert (LED === e) n_pass++;
         else $error("FAIL %s: LED=%h expected %h", tag, LED, e);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      flick = 1'b0;
      push_n(0, 1);
      drain("reset");
`ifdef BOUND_FLASHER_STATE_OUT_EN
      n_chk++;
      assert (state_o === IDLE) n_pass++;
      else $error("FAIL reset_state: state=%0d expected %0d", state_o, IDLE);
`endif
      rst_n = 1'b1;
   endtask

   task automatic pulse();
      flick = 1'b1;
      push_n(1, 1);
      drain("start");
      flick = 1'b0;
   endtask

   initial begin
      // 1: reset and quiet idle
      do_reset();
      push_n(0, 20);
      drain("idle20");

      // 2: single pulse runs the full 56-step pattern
      pulse();
      push_ramp(2, 16);
      push_ramp(15, 5);
      push_ramp(6, 11);
      push_ramp(10, 0);
      push_ramp(1, 6);
      push_ramp(5, 0);
      drain("single");
      push_n(0, 4);
      drain("back_idle");

      // 3: flick held high loops on the lamp5 kickback
      do_reset();
      flick = 1'b1;
      for (int k = 0; k < 3; k++) begin
         push_ramp(1, 6);
         push_ramp(5, 0);
      end
      push_ramp(1, 6);
      drain("held");
      flick = 1'b0;

      // 4: kickback at lamp10 in UP15
      do_reset();
      pulse();
      push_ramp(2, 11);
      drain("grow11");
      flick = 1'b1;
      push_n(10, 1);
      drain("kb11");
      flick = 1'b0;
      push_ramp(9, 0);
      push_ramp(1, 16);
      push_ramp(15, 5);
      drain("regrow");

      // 5: kickback at lamp10 in UP10 repeats the 5..10 segment
      do_reset();
      pulse();
      push_ramp(2, 16);
      push_ramp(15, 5);
      push_ramp(6, 11);
      drain("to_up10");
      flick = 1'b1;
      push_n(10, 1);
      drain("up10_kb");
      flick = 1'b0;
      push_ramp(9, 5);
      push_ramp(6, 11);
      push_ramp(10, 0);
      push_ramp(1, 6);
      push_ramp(5, 0);
      push_n(0, 2);
      drain("repeat");

      // 6: reset mid-sequence, then restart
      do_reset();
      pulse();
      push_ramp(2, 12);
      drain("grow12");
      rst_n = 1'b0;
      push_n(0, 1);
      drain("mid_reset");
      rst_n = 1'b1;
      push_n(0, 3);
      drain("post_reset");
      pulse();
      push_ramp(2, 5);
      drain("restart");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
